// File: rtl/hazard_scoreboard.sv
// Hazard unit: forwarding, load-use and branch control plus a per-register scoreboard for the pipelined multiplier.
// Pipeline controls are combinational; MulBusy and the saturating event counters are registered.
module hazard_scoreboard #(
   parameter int NREGS   = 16,
   parameter int AW      = 4,
   parameter int MUL_LAT = 3,
   parameter int CW      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    RA1D,
   input  logic [AW-1:0]    RA2D,
   input  logic [AW-1:0]    WA3D,
   input  logic             RegWriteD,
   input  logic             MulD,
   input  logic [AW-1:0]    RA1E,
   input  logic [AW-1:0]    RA2E,
   input  logic [AW-1:0]    WA3E,
   input  logic             RegWriteE,
   input  logic             MemtoRegE,
   input  logic             MulE,
   input  logic [AW-1:0]    WA3M,
   input  logic [AW-1:0]    WA3W,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             PCSrcD,
   input  logic             PCSrcE,
   input  logic             PCSrcM,
   input  logic             PCSrcW,
   input  logic             BranchTakenE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [NREGS-1:0] MulBusy,
   output logic [CW-1:0]    StallCount,
   output logic [CW-1:0]    FlushCount
);

   localparam int SBW = $clog2(MUL_LAT + 1);
   localparam logic [SBW-1:0] LAT = SBW'(MUL_LAT);

   logic [SBW-1:0] sb_q [NREGS];
   logic [SBW-1:0] sb_d [NREGS];
   logic [CW-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CW-1:0]  flush_cnt_q, flush_cnt_d;
   logic [NREGS-1:0] busy;
   logic ldr_stall, mul_stall, pc_wr_pending, dst_used;

   // Addresses at or beyond NREGS never match a slot, so they read as not busy.
   function automatic logic sel_busy(input logic [NREGS-1:0] v, input logic [AW-1:0] a);
      sel_busy = 1'b0;
      for (int r = 0; r < NREGS; r++)
         if (a == AW'(r)) sel_busy = v[r];
   endfunction

   function automatic logic [1:0] fwd(input logic [AW-1:0] ra, input logic [AW-1:0] wm,
                                      input logic wem, input logic [AW-1:0] ww, input logic wew);
      if (wem && wm == ra)      fwd = 2'b10;
      else if (wew && ww == ra) fwd = 2'b01;
      else                      fwd = 2'b00;
   endfunction

   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         busy[r] = (sb_q[r] != '0);
         if (MulE && WA3E == AW'(r)) sb_d[r] = LAT;
         else if (sb_q[r] != '0)     sb_d[r] = sb_q[r] - SBW'(1);
         else                        sb_d[r] = sb_q[r];
      end
   end

   always_comb begin
      ForwardAE     = fwd(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
      ForwardBE     = fwd(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);
      dst_used      = RegWriteD | MulD;
      ldr_stall     = MemtoRegE & RegWriteE & (RA1D == WA3E || RA2D == WA3E);
      // The issuing op is not yet in the scoreboard, so match it directly for one cycle.
      mul_stall     = sel_busy(busy, RA1D) | sel_busy(busy, RA2D)
                    | (dst_used & sel_busy(busy, WA3D))
                    | (MulE & (RA1D == WA3E || RA2D == WA3E || (dst_used && WA3D == WA3E)));
      pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;
      StallD        = ldr_stall | mul_stall;
      StallF        = StallD | pc_wr_pending;
      FlushD        = pc_wr_pending | PCSrcW | BranchTakenE;
      FlushE        = StallD | BranchTakenE;
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (StallD && stall_cnt_q != '1)                   stall_cnt_d = stall_cnt_q + CW'(1);
      if ((BranchTakenE | PCSrcW) && flush_cnt_q != '1)  flush_cnt_d = flush_cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NREGS; r++) sb_q[r] <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) sb_q[r] <= sb_d[r];
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign MulBusy    = busy;
   assign StallCount = stall_cnt_q;
   assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed checks with literal expectations plus randomized traffic
// compared every cycle against a ready-time model of the scoreboard.
module tb_hazard_scoreboard;
   localparam int NREGS   = 12;
   localparam int AW      = 4;
   localparam int MUL_LAT = 3;
   localparam int CW      = 4;
   localparam int CMAX    = (1 << CW) - 1;

   logic clk = 1'b0;
   logic reset;
   logic [AW-1:0] RA1D, RA2D, WA3D, RA1E, RA2E, WA3E, WA3M, WA3W;
   logic RegWriteD, MulD, RegWriteE, MemtoRegE, MulE, RegWriteM, RegWriteW;
   logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
   logic [1:0] ForwardAE, ForwardBE;
   logic StallF, StallD, FlushD, FlushE;
   logic [NREGS-1:0] MulBusy;
   logic [CW-1:0] StallCount, FlushCount;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   // Model: each register becomes readable after edge number ready_at[r]; busy while edges seen <= ready_at.
   int ready_at [1 << AW];
   int edge_no;
   int m_sc, m_fc;

   always #5 clk = ~clk;

   hazard_scoreboard #(.NREGS(NREGS), .AW(AW), .MUL_LAT(MUL_LAT), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D), .RegWriteD(RegWriteD), .MulD(MulD),
      .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MulE(MulE),
      .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
      .FlushD(FlushD), .FlushE(FlushE), .MulBusy(MulBusy), .StallCount(StallCount), .FlushCount(FlushCount)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit m_busy(input int a);
      return (a < NREGS) && (edge_no <= ready_at[a]);
   endfunction

   function automatic int m_fwd(input int ra);
      if (RegWriteM && int'(WA3M) == ra) return 2;
      if (RegWriteW && int'(WA3W) == ra) return 1;
      return 0;
   endfunction

   function automatic bit m_stalld();
      bit ldr, mul, used;
      used = RegWriteD | MulD;
      ldr  = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));
      mul  = m_busy(int'(RA1D)) | m_busy(int'(RA2D)) | (used & m_busy(int'(WA3D)))
           | (MulE & ((RA1D == WA3E) | (RA2D == WA3E) | (used & (WA3D == WA3E))));
      return ldr | mul;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < (1 << AW); r++) ready_at[r] = -1;
      edge_no = 0;
      m_sc = 0;
      m_fc = 0;
   endtask

   initial model_clear();
   always @(negedge reset) model_clear();

   always @(posedge clk) begin
      if (!reset) model_clear();
      else begin
         if (m_stalld()) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
         if (BranchTakenE | PCSrcW) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
         if (MulE && int'(WA3E) < NREGS) ready_at[WA3E] = edge_no + MUL_LAT;
         edge_no++;
      end
   end

   // Per-cycle comparison, sampled on the falling edge while inputs are stable.
   always @(negedge clk) begin
      if (chk_en) begin
         bit sd, pcw;
         int busy_vec;
         sd  = m_stalld();
         pcw = PCSrcD | PCSrcE | PCSrcM;
         busy_vec = 0;
         for (int r = 0; r < NREGS; r++) if (m_busy(r)) busy_vec |= (1 << r);
         chk("cyc ForwardAE", int'(ForwardAE), m_fwd(int'(RA1E)));
         chk("cyc ForwardBE", int'(ForwardBE), m_fwd(int'(RA2E)));
         chk("cyc StallD", int'(StallD), int'(sd));
         chk("cyc StallF", int'(StallF), int'(sd | pcw));
         chk("cyc FlushD", int'(FlushD), int'(pcw | PCSrcW | BranchTakenE));
         chk("cyc FlushE", int'(FlushE), int'(sd | BranchTakenE));
         chk("cyc MulBusy", int'(MulBusy), busy_vec);
         chk("cyc StallCount", int'(StallCount), m_sc);
         chk("cyc FlushCount", int'(FlushCount), m_fc);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      {RA1D, RA2D, WA3D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
      {RegWriteD, MulD, RegWriteE, MemtoRegE, MulE, RegWriteM, RegWriteW} = '0;
      {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE} = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #3;
      chk("rst MulBusy", int'(MulBusy), 0);
      chk("rst StallCount", int'(StallCount), 0);
      chk("rst FlushCount", int'(FlushCount), 0);
      chk("rst StallF", int'(StallF), 0);
      chk("rst FlushD", int'(FlushD), 0);
      chk("rst ForwardAE", int'(ForwardAE), 0);
      chk_en = 1;
      step();
      reset = 1'b1;
      step();

      // Forwarding priority
      RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3;
      #1 chk("fwd mem", int'(ForwardAE), 2);
      RegWriteM = 0;
      #1 chk("fwd wb", int'(ForwardAE), 1);
      RA2E = 4;
      #1 chk("fwd none", int'(ForwardBE), 0);
      step(); idle_inputs(); step();

      // Load-use
      MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5;
      #1;
      chk("ldr StallD", int'(StallD), 1);
      chk("ldr StallF", int'(StallF), 1);
      chk("ldr FlushE", int'(FlushE), 1);
      chk("ldr cnt before", int'(StallCount), 0);
      step(); idle_inputs();
      #1 chk("ldr cnt after", int'(StallCount), 1);
      step();

      // Multiplier RAW then WAW: four stall cycles, busy for three
      for (int w = 0; w < 2; w++) begin
         MulE = 1; WA3E = 7;
         if (w == 0) RA1D = 7; else begin WA3D = 7; RegWriteD = 1; end
         for (int i = 0; i < 8; i++) begin
            #1;
            chk(w == 0 ? "raw StallD" : "waw StallD", int'(StallD), (i < 4) ? 1 : 0);
            if (i >= 1 && i <= 3) chk("mul busy7", int'(MulBusy), 12'h080);
            if (i == 4) chk("mul busy clear", int'(MulBusy), 0);
            step();
            MulE = 0; WA3E = 0;
         end
         idle_inputs();
      end
      step();

      // Redirects
      do_reset();
      BranchTakenE = 1;
      #1;
      chk("br FlushD", int'(FlushD), 1);
      chk("br FlushE", int'(FlushE), 1);
      step(); BranchTakenE = 0;
      #1 chk("br FlushCount", int'(FlushCount), 1);
      PCSrcD = 1;
      #1;
      chk("pcd StallF", int'(StallF), 1);
      chk("pcd FlushD", int'(FlushD), 1);
      chk("pcd StallD", int'(StallD), 0);
      PCSrcD = 0; PCSrcW = 1;
      #1;
      chk("pcw FlushD", int'(FlushD), 1);
      chk("pcw StallF", int'(StallF), 0);
      step(); PCSrcW = 0;
      #1 chk("pcw FlushCount", int'(FlushCount), 2);

      // Async reset mid-cycle with busy and stall count of nine
      do_reset();
      MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA1D = 5;
      repeat (8) step();
      MemtoRegE = 0; RegWriteE = 0; MulE = 1; WA3E = 7; RA1D = 7;
      step();
      idle_inputs();
      #1;
      chk("pre-rst StallCount", int'(StallCount), 9);
      chk("pre-rst busy7", int'(MulBusy[7]), 1);
      reset = 1'b0;
      #1;
      chk("async MulBusy", int'(MulBusy), 0);
      chk("async StallCount", int'(StallCount), 0);
      step();
      reset = 1'b1;
      repeat (3) step();
      chk("post-rst MulBusy", int'(MulBusy), 0);
      chk("post-rst StallCount", int'(StallCount), 0);

      // Saturation
      MemtoRegE = 1; RegWriteE = 1; WA3E = 2; RA2D = 2;
      repeat (20) step();
      chk("sat StallCount", int'(StallCount), CMAX);
      idle_inputs();
      step();

      // Randomized traffic checked by the per-cycle model
      for (int c = 0; c < 2000; c++) begin
         step();
         reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         RA1D = AW'($urandom); RA2D = AW'($urandom); WA3D = AW'($urandom);
         RA1E = AW'($urandom); RA2E = AW'($urandom); WA3E = AW'($urandom);
         WA3M = AW'($urandom); WA3W = AW'($urandom);
         RegWriteD = 1'($urandom); MulD = ($urandom_range(0, 3) == 0);
         MulE = ($urandom_range(0, 3) == 0);
         RegWriteE = MulE ? 1'b0 : 1'($urandom);
         MemtoRegE = 1'($urandom);
         RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
         PCSrcD = ($urandom_range(0, 15) == 0); PCSrcE = ($urandom_range(0, 15) == 0);
         PCSrcM = ($urandom_range(0, 15) == 0); PCSrcW = ($urandom_range(0, 15) == 0);
         BranchTakenE = ($urandom_range(0, 7) == 0);
      end
      step();
      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
